// File: rtl/alu_cmd_issuer.sv
// alu_cmd_issuer: FIFO-buffered command issuer for a combinational ALU with valid/ready responses
//   clk_i, rst_i (async, active-low)
//   cmd_valid_i/cmd_ready_o, cmd_src1_i, cmd_src2_i, cmd_funct_i : command push port
//   Src1, Src2, Funct                                            : operands held on the ALU
//   ALU_result, ALU_Carry                                        : ALU outputs, captured after settling
//   rsp_valid_o/rsp_ready_i, rsp_result_o, rsp_carry_o, rsp_funct_o : response port
//   busy_o, cmd_count_o                                          : FSM not idle, FIFO occupancy
module alu_cmd_issuer #(
    parameter int DATA_W     = 32,
    parameter int FUNCT_W    = 6,
    parameter int FIFO_DEPTH = 4,
    parameter int SETTLE     = 1
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic                              cmd_valid_i,
    output logic                              cmd_ready_o,
    input  logic [DATA_W-1:0]                 cmd_src1_i,
    input  logic [DATA_W-1:0]                 cmd_src2_i,
    input  logic [FUNCT_W-1:0]                cmd_funct_i,
    output logic [DATA_W-1:0]                 Src1,
    output logic [DATA_W-1:0]                 Src2,
    output logic [FUNCT_W-1:0]                Funct,
    input  logic [DATA_W-1:0]                 ALU_result,
    input  logic                              ALU_Carry,
    output logic                              rsp_valid_o,
    input  logic                              rsp_ready_i,
    output logic [DATA_W-1:0]                 rsp_result_o,
    output logic                              rsp_carry_o,
    output logic [FUNCT_W-1:0]                rsp_funct_o,
    output logic                              busy_o,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   cmd_count_o
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;
    state_t             r_state;
    logic [AW-1:0]      r_wr_ptr, r_rd_ptr;
    logic [CW-1:0]      r_count;
    logic [SW-1:0]      r_ctr;
    logic [DATA_W-1:0]  r_mem_src1 [FIFO_DEPTH];
    logic [DATA_W-1:0]  r_mem_src2 [FIFO_DEPTH];
    logic [FUNCT_W-1:0] r_mem_funct [FIFO_DEPTH];
    logic               w_push, w_pop;
    assign cmd_ready_o = r_count < CW'(FIFO_DEPTH);
    assign cmd_count_o = r_count;
    assign busy_o      = r_state != IDLE;
    assign w_push      = cmd_valid_i && cmd_ready_o;
    // Pop uses the occupancy before this edge, so a command pushed on the same edge waits a cycle.
    assign w_pop       = (r_count != '0) && (r_state == IDLE || (r_state == RESP && rsp_ready_i));
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem_src1[r_wr_ptr]  <= cmd_src1_i;
            r_mem_src2[r_wr_ptr]  <= cmd_src2_i;
            r_mem_funct[r_wr_ptr] <= cmd_funct_i;
        end
    end
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state      <= IDLE;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_ctr        <= '0;
            Src1         <= '0;
            Src2         <= '0;
            Funct        <= '0;
            rsp_valid_o  <= 1'b0;
            rsp_result_o <= '0;
            rsp_carry_o  <= 1'b0;
            rsp_funct_o  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
            if (r_state == ISSUE) begin
                if (r_ctr == '0) begin
                    rsp_result_o <= ALU_result;
                    rsp_carry_o  <= ALU_Carry;
                    rsp_funct_o  <= Funct;
                    rsp_valid_o  <= 1'b1;
                    r_state      <= RESP;
                end else begin
                    r_ctr <= r_ctr - SW'(1);
                end
            end else if (r_state == RESP && rsp_ready_i) begin
                rsp_valid_o <= 1'b0;
                r_state     <= IDLE;
            end
            // A pop overrides the IDLE fallback above, chaining straight into the next issue.
            if (w_pop) begin
                Src1    <= r_mem_src1[r_rd_ptr];
                Src2    <= r_mem_src2[r_rd_ptr];
                Funct   <= r_mem_funct[r_rd_ptr];
                r_ctr   <= SW'(SETTLE - 1);
                r_state <= ISSUE;
            end
        end
    end
endmodule
